// File: rtl/ime_pkg.sv
// Shared integer-ME definitions: MVD/cost/SAD widths, comparator pipeline depth
// and the comparator FSM state encoding.
package ime_pkg;
  localparam int IMVD_LEN     = 6;
  localparam int MV_COST_BITS = 12;
  localparam int SAD_W        = 16;
  localparam int PIPE_STAGES  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } ime_state_e;
endpackage

// File: rtl/ime_mvd_sat.sv
// One MVD axis: a - b at W+1 bits, saturated back into signed W bits.
module ime_mvd_sat #(
  parameter int W = 6
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] d
);
  logic [W:0] diff;

  assign diff = {a[W-1], a} - {b[W-1], b};

  // the two top bits disagree only when the difference left W-bit range
  always_comb begin
    d = diff[W-1:0];
    if (diff[W] != diff[W-1])
      d = diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end
endmodule

// File: rtl/ime_cost_cmp.sv
// Integer-ME candidate comparator wrapped around ime_mv_cost: emits saturated MVDs,
// adds returned rate cost to SAD, keeps the min-cost MV. IME_CMP_STAT_EN adds cand_cnt_o.
module ime_cost_cmp
  import ime_pkg::*;
#(
  parameter int MV_W   = IMVD_LEN,
  parameter int COST_W = MV_COST_BITS,
  parameter int SAD_W  = ime_pkg::SAD_W,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic [MV_W-1:0]   pmv_x_i,
  input  logic [MV_W-1:0]   pmv_y_i,
  input  logic              cand_valid_i,
  input  logic              cand_last_i,
  input  logic [MV_W-1:0]   cand_mv_x_i,
  input  logic [MV_W-1:0]   cand_mv_y_i,
  output logic [MV_W-1:0]   mvd_x_o,
  output logic [MV_W-1:0]   mvd_y_o,
  input  logic [COST_W-1:0] mv_cost_i,
  input  logic [SAD_W-1:0]  sad_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [MV_W-1:0]   best_mv_x_o,
  output logic [MV_W-1:0]   best_mv_y_o,
  output logic [SAD_W:0]    best_cost_o
`ifdef IME_CMP_STAT_EN
  ,
  output logic [CNT_W-1:0]  cand_cnt_o
`endif
);
  ime_state_e state_q, state_d;
  logic       drain_q;
  logic       accept, fin, upd;

  // axis index: [0]=x, [1]=y
  logic [1:0][MV_W-1:0] cand_mv, pmv, pmv_q, mvd_d, mvd_q;
  logic [1:0][MV_W-1:0] best_mv_q, best_out_q, nxt_mv;
  logic [PIPE_STAGES:1][1:0][MV_W-1:0] mv_pipe;
  logic [PIPE_STAGES:1] vld_q;
  logic [PIPE_STAGES:0] vld_pipe;
  logic [SAD_W:0] total, best_cost_q, nxt_cost;

  assign cand_mv = {cand_mv_y_i, cand_mv_x_i};
  assign pmv     = {pmv_y_i, pmv_x_i};

  for (genvar a = 0; a < 2; a++) begin : g_ax
    ime_mvd_sat #(.W(MV_W)) u_sat (
      .a (cand_mv[a]),
      .b (pmv_q[a]),
      .d (mvd_d[a])
    );
  end

  // a start in the same cycle wins over any candidate
  assign accept   = (state_q == ST_SEARCH) && cand_valid_i && !start_i;
  assign vld_pipe = {vld_q, accept};
  assign fin      = (state_q == ST_DRAIN) && drain_q && !start_i;

  assign total    = {1'b0, sad_i} + {{(SAD_W+1-COST_W){1'b0}}, mv_cost_i};
  assign upd      = vld_pipe[PIPE_STAGES] && (total < best_cost_q);
  assign nxt_cost = upd ? total : best_cost_q;
  assign nxt_mv   = upd ? mv_pipe[PIPE_STAGES] : best_mv_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_IDLE;
      ST_SEARCH: if (cand_valid_i && cand_last_i) state_d = ST_DRAIN;
      ST_DRAIN:  if (drain_q) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (start_i) state_d = ST_SEARCH;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      drain_q     <= 1'b0;
      vld_q       <= '0;
      mv_pipe     <= '0;
      pmv_q       <= '0;
      mvd_q       <= '0;
      best_mv_q   <= '0;
      best_cost_q <= '1;
      best_out_q  <= '0;
      best_cost_o <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= (state_q == ST_DRAIN) && !drain_q && !start_i;
      mv_pipe <= {mv_pipe[PIPE_STAGES-1:1], cand_mv};
      if (accept) mvd_q <= mvd_d;
      if (start_i) begin
        pmv_q       <= pmv;
        vld_q       <= '0;
        best_cost_q <= '1;
      end else begin
        vld_q <= vld_pipe[PIPE_STAGES-1:0];
        if (upd) begin
          best_cost_q <= total;
          best_mv_q   <= mv_pipe[PIPE_STAGES];
        end
      end
      // last candidate's compare resolves on the same edge that publishes
      if (fin) begin
        best_out_q  <= nxt_mv;
        best_cost_o <= nxt_cost;
      end
    end
  end

`ifdef IME_CMP_STAT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                      cand_cnt_o <= '0;
    else if (start_i)               cand_cnt_o <= '0;
    else if (accept && !(&cand_cnt_o)) cand_cnt_o <= cand_cnt_o + 1'b1;
  end
`endif

  assign mvd_x_o     = mvd_q[0];
  assign mvd_y_o     = mvd_q[1];
  assign best_mv_x_o = best_out_q[0];
  assign best_mv_y_o = best_out_q[1];
  assign busy_o      = (state_q == ST_SEARCH) || (state_q == ST_DRAIN);
  assign done_o      = (state_q == ST_DONE);
endmodule

// File: tb/tb_ime_cost_cmp.sv
// Scoreboard bench for ime_cost_cmp: stimulus queues expected MVDs and round results,
// a negedge monitor pops and compares; SAD/cost are returned two cycles after a candidate.
module tb_ime_cost_cmp;
  localparam int MV_W = 6, COST_W = 12, SAD_W = 16, CNT_W = 10;

  logic clk = 1'b0, rstn = 1'b0;
  logic start_i = 1'b0, cand_valid_i = 1'b0, cand_last_i = 1'b0;
  logic [MV_W-1:0] pmv_x_i = '0, pmv_y_i = '0, cand_mv_x_i = '0, cand_mv_y_i = '0;
  logic [MV_W-1:0] mvd_x_o, mvd_y_o, best_mv_x_o, best_mv_y_o;
  logic [COST_W-1:0] mv_cost_i;
  logic [SAD_W-1:0] sad_i;
  logic [SAD_W:0] best_cost_o;
  logic busy_o, done_o;
`ifdef IME_CMP_STAT_EN
  logic [CNT_W-1:0] cand_cnt_o;
`endif

  ime_cost_cmp #(.MV_W(MV_W), .COST_W(COST_W), .SAD_W(SAD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i),
    .pmv_x_i(pmv_x_i), .pmv_y_i(pmv_y_i),
    .cand_valid_i(cand_valid_i), .cand_last_i(cand_last_i),
    .cand_mv_x_i(cand_mv_x_i), .cand_mv_y_i(cand_mv_y_i),
    .mvd_x_o(mvd_x_o), .mvd_y_o(mvd_y_o),
    .mv_cost_i(mv_cost_i), .sad_i(sad_i),
    .busy_o(busy_o), .done_o(done_o),
    .best_mv_x_o(best_mv_x_o), .best_mv_y_o(best_mv_y_o),
    .best_cost_o(best_cost_o)
`ifdef IME_CMP_STAT_EN
    , .cand_cnt_o(cand_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int cost; int due;} res_t;
  typedef struct {int x; int y;} mvd_t;
  res_t res_q[$];
  mvd_t mvd_q[$];
  int n_cmp = 0, n_err = 0, cyc = 0;
  int cur_px = 0, cur_py = 0;
  logic acc_now = 1'b0, acc_d1 = 1'b0;
  logic [SAD_W-1:0]  sad_c = '0, sad_d1 = '0, sad_d2 = '0;
  logic [COST_W-1:0] cost_c = '0, cost_d1 = '0, cost_d2 = '0;

  // stand-in for ime_mv_cost + SAD engine: values appear two cycles after the candidate
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    acc_d1  <= acc_now;
    sad_d1  <= sad_c;  sad_d2  <= sad_d1;
    cost_d1 <= cost_c; cost_d2 <= cost_d1;
  end
  assign sad_i     = sad_d2;
  assign mv_cost_i = cost_d2;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sat(int v);
    if (v > 2**(MV_W-1)-1) return 2**(MV_W-1)-1;
    if (v < -(2**(MV_W-1))) return -(2**(MV_W-1));
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic start(int px, int py);
    start_i = 1'b1; pmv_x_i = MV_W'(px); pmv_y_i = MV_W'(py);
    cur_px = px; cur_py = py;
    tick();
    start_i = 1'b0;
  endtask

  task automatic expect_res(int x, int y, int cost);
    res_t r;
    r.x = x; r.y = y; r.cost = cost; r.due = cyc + 3;
    res_q.push_back(r);
  endtask

  task automatic cand(int x, int y, int sad, int cost, bit last, bit exp_acc);
    mvd_t m;
    cand_valid_i = 1'b1; cand_last_i = last;
    cand_mv_x_i = MV_W'(x); cand_mv_y_i = MV_W'(y);
    sad_c = SAD_W'(sad); cost_c = COST_W'(cost);
    acc_now = exp_acc;
    if (exp_acc) begin
      m.x = sat(x - cur_px); m.y = sat(y - cur_py);
      mvd_q.push_back(m);
    end
    tick();
    cand_valid_i = 1'b0; cand_last_i = 1'b0; acc_now = 1'b0;
    sad_c = '0; cost_c = '0;
  endtask

  always @(negedge clk) begin : mon
    res_t r;
    mvd_t m;
    if (rstn) begin
      if (acc_d1) begin
        if (mvd_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL mvd_queue: no expected MVD for accepted candidate");
        end else begin
          m = mvd_q.pop_front();
          chk("mvd_x", $signed(mvd_x_o), m.x);
          chk("mvd_y", $signed(mvd_y_o), m.y);
        end
      end
      if (done_o) begin
        if (res_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: got done_o=1 required 0 at cycle %0d", cyc);
        end else begin
          r = res_q.pop_front();
          chk("done_cycle", cyc, r.due);
          chk("best_mv_x", $signed(best_mv_x_o), r.x);
          chk("best_mv_y", $signed(best_mv_y_o), r.y);
          chk("best_cost", int'(best_cost_o), r.cost);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    chk("rst_done", done_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_best_cost", int'(best_cost_o), 0);
    chk("rst_best_x", int'(best_mv_x_o), 0);
    chk("rst_mvd_x", int'(mvd_x_o), 0);
    rstn = 1'b1;
    idle(1);

    // basic round: totals 40, 25, 30
    start(0, 0);
    chk("busy_search", busy_o, 1);
    cand(1, 0, 30, 10, 0, 1);
    cand(-2, 3, 20, 5, 0, 1);
    expect_res(-2, 3, 25);
    cand(0, 0, 28, 2, 1, 1);
    chk("busy_drain", busy_o, 1);
    idle(4);
    chk("busy_idle", busy_o, 0);

    // MVD saturation on both axes; previous result held during SEARCH
    start(20, -20);
    chk("best_hold", int'(best_cost_o), 25);
    expect_res(-30, 30, 100);
    cand(-30, 30, 60, 40, 1, 1);
    idle(4);

    // tie at total 50: earlier candidate wins
    start(0, 0);
    cand(3, 3, 40, 10, 0, 1);
    expect_res(3, 3, 50);
    cand(4, 4, 45, 5, 1, 1);
    idle(4);

    // max SAD + max cost, opposite-direction saturation
    start(-32, 31);
    expect_res(31, -32, 69630);
    cand(31, -32, 65535, 4095, 1, 1);
    idle(4);

    // abort mid-SEARCH: the cheap aborted candidate must not leak
    start(0, 0);
    cand(5, 5, 1, 0, 0, 1);
    start(1, 1);
    expect_res(2, -1, 7);
    cand(2, -1, 4, 3, 1, 1);
    idle(4);

    // reset during DRAIN discards the round
    start(0, 0);
    cand(7, 7, 3, 3, 1, 1);
    tick();
    rstn = 1'b0;
    #1;
    chk("rstdrain_done", done_o, 0);
    chk("rstdrain_busy", busy_o, 0);
    chk("rstdrain_cost", int'(best_cost_o), 0);
    chk("rstdrain_best_y", int'(best_mv_y_o), 0);
    chk("rstdrain_mvd_y", int'(mvd_y_o), 0);
    tick();
    rstn = 1'b1;
    idle(4);
    start(0, 0);
    expect_res(-1, -1, 9);
    cand(-1, -1, 5, 4, 1, 1);
    idle(4);

    // candidates presented in IDLE are ignored
    cand(9, 9, 1, 1, 0, 0);
    cand(9, 9, 1, 1, 1, 0);
    start(0, 0);
    cand(1, 1, 10, 0, 0, 1);
    cand(2, 2, 9, 0, 0, 1);
    expect_res(3, 3, 8);
    cand(3, 3, 8, 0, 1, 1);
    idle(4);
`ifdef IME_CMP_STAT_EN
    chk("cand_cnt", int'(cand_cnt_o), 3);
    idle(2);
    chk("cand_cnt_hold", int'(cand_cnt_o), 3);
`endif

    chk("results_pending", res_q.size(), 0);
    chk("mvd_pending", mvd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
